// File: rtl/sincos_mul_if.sv
// Sample/phase bundle between the carrier source and the IQ multiplier,
// with the registered products returned to the DAC side.
interface sincos_mul_if #(
    parameter int IQ_W = 8
);
    logic        [4:0]      tphase;
    logic signed [IQ_W-1:0] i;
    logic signed [IQ_W-1:0] q;
    logic signed [8:0]      icos;
    logic signed [8:0]      qsin;

    modport master (
        output tphase, i, q,
        input  icos, qsin
    );

    modport slave (
        input  tphase, i, q,
        output icos, qsin
    );
endinterface

// File: rtl/sincos_mul.sv
// IQ modulator core: registered i*cos(phase) and q*sin(phase), scaled by 1/128.
// Define SINCOS_ROUND_EN for round-half-up scaling instead of floor truncation.
module sincos_mul #(
    parameter int IQ_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    sincos_mul_if.slave bus
);

`ifdef SINCOS_ROUND_EN
    localparam logic signed [31:0] RND = 32'sd64;
`else
    localparam logic signed [31:0] RND = 32'sd0;
`endif

    function automatic logic signed [7:0] quarterLut(input logic [3:0] idx);
        logic signed [7:0] v;
        case (idx)
            4'd0:    v = 8'sd127;
            4'd1:    v = 8'sd125;
            4'd2:    v = 8'sd117;
            4'd3:    v = 8'sd106;
            4'd4:    v = 8'sd90;
            4'd5:    v = 8'sd71;
            4'd6:    v = 8'sd49;
            4'd7:    v = 8'sd25;
            default: v = 8'sd0;
        endcase
        return v;
    endfunction

    // Quarter-wave cosine; the 5-bit index arithmetic wraps modulo 32 naturally.
    function automatic logic signed [7:0] cosLut(input logic [4:0] k);
        logic signed [7:0] v;
        if (k <= 5'd8)
            v = quarterLut(4'(k));
        else if (k <= 5'd16)
            v = -quarterLut(4'(5'd16 - k));
        else if (k <= 5'd24)
            v = -quarterLut(4'(k - 5'd16));
        else
            v = quarterLut(4'(5'd0 - k));
        return v;
    endfunction

    logic signed [7:0] cosVal;
    logic signed [7:0] sinVal;
    logic signed [8:0] icos_d, icos_q;
    logic signed [8:0] qsin_d, qsin_q;

    always_comb begin
        cosVal = cosLut(bus.tphase);
        sinVal = cosLut(bus.tphase + 5'd24);
        icos_d = 9'(((32'(bus.i) * 32'(cosVal)) + RND) >>> 7);
        qsin_d = 9'(((32'(bus.q) * 32'(sinVal)) + RND) >>> 7);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            icos_q <= '0;
            qsin_q <= '0;
        end else begin
            icos_q <= icos_d;
            qsin_q <= qsin_d;
        end
    end

    assign bus.icos = icos_q;
    assign bus.qsin = qsin_q;

endmodule

// File: tb/tb_sincos_mul.sv
// Self-checking bench for sincos_mul: directed cases, a full phase sweep and
// random vectors against a trig-based reference model.
module tb_sincos_mul;
    localparam int IQ_W = 8;

    logic clk;
    logic rst;
    int   numCompared;
    int   numMismatched;

    sincos_mul_if #(.IQ_W(IQ_W)) bus ();

    sincos_mul #(.IQ_W(IQ_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int refCos(input int k);
        real v;
        v = 127.0 * $cos(2.0 * 3.14159265358979 * real'(k) / 32.0);
        return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
    endfunction

    // Expected scaled product; sine is the cosine shifted back a quarter turn.
    function automatic int expectOut(input int sample, input int k, input bit isSin);
        int tab;
        int p;
        tab = isSin ? refCos((k + 24) % 32) : refCos(k % 32);
        p = sample * tab;
`ifdef SINCOS_ROUND_EN
        p = p + 64;
`endif
        return p >>> 7;
    endfunction

    task automatic checkOutput(input string tag, input int observed, input int expected);
        numCompared++;
        if (observed !== expected) begin
            numMismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, then check the registered result after the edge.
    task automatic applyStimulus(input string tag, input int tp, input int iv,
                                 input int qv, input bit r);
        int expI;
        int expQ;
        rst        = r;
        bus.tphase = 5'(tp);
        bus.i      = IQ_W'(iv);
        bus.q      = IQ_W'(qv);
        expI = r ? 0 : expectOut(iv, tp, 1'b0);
        expQ = r ? 0 : expectOut(qv, tp, 1'b1);
        @(posedge clk);
        #1;
        checkOutput({tag, ".icos"}, int'(bus.icos), expI);
        checkOutput({tag, ".qsin"}, int'(bus.qsin), expQ);
    endtask

    initial begin
        int quarter[9];
        numCompared   = 0;
        numMismatched = 0;
        rst        = 1'b1;
        bus.tphase = '0;
        bus.i      = '0;
        bus.q      = '0;
        @(posedge clk);
        #1;

        quarter = '{127, 125, 117, 106, 90, 71, 49, 25, 0};
        for (int k = 0; k <= 8; k++)
            checkOutput($sformatf("model.cos%0d", k), refCos(k), quarter[k]);

        applyStimulus("reset0", 3, 100, 50, 1'b1);
        applyStimulus("reset1", 3, 100, 50, 1'b1);
        applyStimulus("release", 3, 100, 50, 1'b0);
        applyStimulus("phase0", 0, 100, 50, 1'b0);
        applyStimulus("phase8", 8, 100, 50, 1'b0);
        applyStimulus("phase16", 16, 100, 50, 1'b0);
        applyStimulus("extreme4", 4, -128, -128, 1'b0);
        applyStimulus("extreme0", 0, -128, -128, 1'b0);
        applyStimulus("wrap30", 30, 127, 127, 1'b0);
        applyStimulus("wrap31", 31, 127, 127, 1'b0);
        applyStimulus("wrap0", 0, 127, 127, 1'b0);
        applyStimulus("wrap2", 2, 127, 127, 1'b0);

        for (int k = 0; k < 32; k++)
            applyStimulus($sformatf("sweep%0d", k), k, 127, 127, 1'b0);

        for (int n = 0; n < 300; n++)
            applyStimulus($sformatf("rand%0d", n), int'($urandom_range(0, 31)),
                          $signed(8'($urandom)), $signed(8'($urandom)),
                          ($urandom_range(0, 19) == 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
        $finish;
    end
endmodule
